// File: rtl/pio_input_conditioner_if.sv
// Board-side PIO bundle: raw button/switch inputs in, debounced levels and event pulses out.
interface pio_input_conditioner_if #(
    parameter int N_BTN = 4,
    parameter int N_SW  = 8
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] button_pio_export;
    logic [N_SW-1:0]  switch_pio_export;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_SW-1:0]  sw_change;
    logic             any_event;

    modport slave (
        input  btn_raw, sw_raw,
        output button_pio_export, switch_pio_export, btn_press, btn_release, sw_change, any_event
    );

    modport master (
        output btn_raw, sw_raw,
        input  button_pio_export, switch_pio_export, btn_press, btn_release, sw_change, any_event
    );
endinterface

// File: rtl/pio_input_conditioner.sv
// Two-flop synchronise and per-bit debounce of buttons/switches, with registered edge pulses.
// Latency DEBOUNCE_CYCLES+2 edges from first sample; no backpressure, outputs are free-running levels/pulses.
module pio_input_conditioner #(
    parameter int N_BTN           = 4,
    parameter int N_SW            = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input logic clk_clk,
    input logic reset_reset,
    pio_input_conditioner_if.slave pio
);
    localparam int N = N_BTN + N_SW;
    // Buttons idle high (active-low), switches idle low.
    localparam logic [N-1:0]     RST_VAL = {{N_SW{1'b0}}, {N_BTN{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     s1_q, s2_q;
    logic [N-1:0]     stable_q, stable_d;
    logic [N-1:0]     rise_q, rise_d;
    logic [N-1:0]     fall_q, fall_d;
    logic             any_q, any_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];

    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = s2_q[i];
                    rise_d[i]   = s2_q[i];
                    fall_d[i]   = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s1_q     <= RST_VAL;
            s2_q     <= RST_VAL;
            stable_q <= RST_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
            any_q    <= 1'b0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            s1_q     <= {pio.sw_raw, pio.btn_raw};
            s2_q     <= s1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            any_q    <= any_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Active-low buttons: a press is a fall of the debounced level.
    assign pio.button_pio_export = stable_q[N_BTN-1:0];
    assign pio.switch_pio_export = stable_q[N-1:N_BTN];
    assign pio.btn_press         = fall_q[N_BTN-1:0];
    assign pio.btn_release       = rise_q[N_BTN-1:0];
    assign pio.sw_change         = rise_q[N-1:N_BTN] | fall_q[N-1:N_BTN];
    assign pio.any_event         = any_q;
endmodule

// File: tb/tb_pio_input_conditioner.sv
// Directed bench for pio_input_conditioner with DEBOUNCE_CYCLES=8; expected events queued at drive time.
module tb_pio_input_conditioner;
    localparam int D = 8;

    typedef struct {
        int         cyc;
        logic [3:0] bp;
        logic [3:0] br;
        logic [7:0] sc;
        logic [3:0] btn;
        logic [7:0] sw;
    } exp_t;

    logic clk_clk;
    logic reset_reset;
    logic rst_at_edge;
    logic mon_en;
    int   cyc;
    int   checks;
    int   failures;
    exp_t q[$];
    logic [3:0] m_btn;
    logic [7:0] m_sw;

    pio_input_conditioner_if #(.N_BTN(4), .N_SW(8)) pio ();

    pio_input_conditioner #(
        .N_BTN(4), .N_SW(8), .DEBOUNCE_CYCLES(D), .CNT_W(16)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .pio         (pio.slave)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    initial cyc = 0;
    always @(posedge clk_clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset_reset;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Monitor: every cycle compares all outputs to the model; pulses are zero unless an entry is due.
    always @(negedge clk_clk) begin
        logic [3:0] e_bp, e_br;
        logic [7:0] e_sc;
        exp_t e;
        if (mon_en) begin
            e_bp = '0;
            e_br = '0;
            e_sc = '0;
            if (rst_at_edge) begin
                m_btn = 4'hF;
                m_sw  = 8'h00;
            end else if (q.size() > 0 && q[0].cyc == cyc) begin
                e     = q.pop_front();
                e_bp  = e.bp;
                e_br  = e.br;
                e_sc  = e.sc;
                m_btn = e.btn;
                m_sw  = e.sw;
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                failures++;
                $error("FAIL missed_event cyc=%0d observed=none expected_at=%0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            chk("button_pio_export", {4'h0, pio.button_pio_export}, {4'h0, m_btn});
            chk("switch_pio_export", pio.switch_pio_export, m_sw);
            chk("btn_press", {4'h0, pio.btn_press}, {4'h0, e_bp});
            chk("btn_release", {4'h0, pio.btn_release}, {4'h0, e_br});
            chk("sw_change", pio.sw_change, e_sc);
            chk("any_event", {7'h0, pio.any_event}, {7'h0, |{e_bp, e_br, e_sc}});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic expect_evt(input int dly, input logic [3:0] bp, input logic [3:0] br,
                              input logic [7:0] sc, input logic [3:0] btn, input logic [7:0] sw);
        exp_t e;
        e.cyc = cyc + dly;
        e.bp  = bp;
        e.br  = br;
        e.sc  = sc;
        e.btn = btn;
        e.sw  = sw;
        q.push_back(e);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        mon_en      = 1'b0;
        reset_reset = 1'b1;
        pio.btn_raw = 4'b0000;
        pio.sw_raw  = 8'hFF;

        // Reset with inputs opposite to reset values; outputs must stay reset one cycle past deassert.
        step(3);
        mon_en = 1'b1;
        step(2);
        reset_reset = 1'b0;
        step(1);
        pio.btn_raw = 4'hF;
        pio.sw_raw  = 8'h00;
        step(12);

        // Clean press on button 2.
        pio.btn_raw[2] = 1'b0;
        expect_evt(D + 2, 4'b0100, 4'b0000, 8'h00, 4'hB, 8'h00);
        step(15);

        // Switch 5 high for D-1 cycles: rejected.
        pio.sw_raw[5] = 1'b1;
        step(D - 1);
        pio.sw_raw[5] = 1'b0;
        step(15);

        // Switch 5 high for exactly D cycles: accepted, then the return low is accepted too.
        pio.sw_raw[5] = 1'b1;
        expect_evt(D + 2, 4'b0000, 4'b0000, 8'h20, 4'hB, 8'h20);
        step(D);
        pio.sw_raw[5] = 1'b0;
        expect_evt(D + 2, 4'b0000, 4'b0000, 8'h20, 4'hB, 8'h00);
        step(15);

        // Bounce button 0 every 3 cycles, then hold pressed.
        for (int k = 0; k < 10; k++) begin
            pio.btn_raw[0] = k[0];
            step(3);
        end
        pio.btn_raw[0] = 1'b0;
        expect_evt(D + 2, 4'b0001, 4'b0000, 8'h00, 4'hA, 8'h00);
        step(15);

        // Simultaneous press of buttons 1,3 and switch 0,7 flip.
        pio.btn_raw = 4'b0000;
        pio.sw_raw  = 8'h81;
        expect_evt(D + 2, 4'b1010, 4'b0000, 8'h81, 4'h0, 8'h81);
        step(15);

        // Release everything at once.
        pio.btn_raw = 4'hF;
        pio.sw_raw  = 8'h00;
        expect_evt(D + 2, 4'b0000, 4'b1111, 8'h81, 4'hF, 8'h00);
        step(15);

        // Reset mid-count discards progress; acceptance restarts after deassert.
        pio.sw_raw[0] = 1'b1;
        step(7);
        reset_reset = 1'b1;
        step(3);
        reset_reset = 1'b0;
        expect_evt(D + 2, 4'b0000, 4'b0000, 8'h01, 4'hF, 8'h01);
        step(15);

        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL queue_drained observed=%0d expected=0", q.size());
        end
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
